// File: rtl/traffic_pkg.sv
// Shared state encoding, light encodings and phase sequencing for traffic_controller.
// The FLASH state exists only when TRAFFIC_FLASH_MODE_EN is defined.
package traffic_pkg;

`ifdef TRAFFIC_FLASH_MODE_EN
    typedef enum logic [2:0] {
        NS_GREEN  = 3'd0,
        NS_YELLOW = 3'd1,
        CLEAR_A   = 3'd2,
        EW_GREEN  = 3'd3,
        EW_YELLOW = 3'd4,
        CLEAR_B   = 3'd5,
        FLASH     = 3'd6
    } state_t;
`else
    typedef enum logic [2:0] {
        NS_GREEN  = 3'd0,
        NS_YELLOW = 3'd1,
        CLEAR_A   = 3'd2,
        EW_GREEN  = 3'd3,
        EW_YELLOW = 3'd4,
        CLEAR_B   = 3'd5
    } state_t;
`endif

    localparam logic [2:0] LIGHT_GREEN  = 3'd1;
    localparam logic [2:0] LIGHT_YELLOW = 3'd2;
    localparam logic [2:0] LIGHT_RED    = 3'd4;
    localparam logic [2:0] LIGHT_DARK   = 3'd0;

    function automatic state_t next_phase(input state_t s);
        state_t n;
        case (s)
            NS_GREEN:  n = NS_YELLOW;
            NS_YELLOW: n = CLEAR_A;
            CLEAR_A:   n = EW_GREEN;
            EW_GREEN:  n = EW_YELLOW;
            EW_YELLOW: n = CLEAR_B;
            CLEAR_B:   n = NS_GREEN;
            default:   n = CLEAR_B;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/traffic_controller_phase_timer.sv
// Phase down-counter: reset value, load, force-load of a fixed value, tick-enabled
// decrement that stops at zero, and a zero flag.
module phase_timer #(
    parameter int unsigned            CNT_W       = 3,
    parameter logic [CNT_W-1:0]       FORCE_VALUE = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [CNT_W-1:0] rst_value,
    input  logic             load,
    input  logic [CNT_W-1:0] load_value,
    input  logic             force_load,
    input  logic             tick,
    output logic [CNT_W-1:0] cnt,
    output logic             zero
);

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= rst_value;
        end else if (load) begin
            cnt <= load_value;
        end else if (force_load) begin
            cnt <= FORCE_VALUE;
        end else if (tick && cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/traffic_controller.sv
// Two-approach intersection controller with all-red clearance and pedestrian truncation.
// Optional flashing-yellow mode with flash_req input: define TRAFFIC_FLASH_MODE_EN.
module traffic_controller
    import traffic_pkg::*;
#(
    parameter int unsigned GREEN_TICKS  = 5,
    parameter int unsigned YELLOW_TICKS = 2,
    parameter int unsigned CLEAR_TICKS  = 1,
    parameter int unsigned MIN_GREEN    = 2,
    parameter int unsigned CNT_W        = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rst_type,
    input  logic       tick,
    input  logic       ped_req,
`ifdef TRAFFIC_FLASH_MODE_EN
    input  logic       flash_req,
`endif
    output logic [2:0] light_ns,
    output logic [2:0] light_ew,
    output logic       walk_ns,
    output logic       walk_ew,
    output logic       ped_pend
);

    localparam logic [CNT_W-1:0] G_LOAD   = CNT_W'(GREEN_TICKS - 1);
    localparam logic [CNT_W-1:0] Y_LOAD   = CNT_W'(YELLOW_TICKS - 1);
    localparam logic [CNT_W-1:0] C_LOAD   = CNT_W'(CLEAR_TICKS - 1);
    localparam logic [CNT_W-1:0] MIN_LOAD = CNT_W'(MIN_GREEN - 1);

    state_t           state, state_next;
    logic [CNT_W-1:0] cnt, t_load_value;
    logic             zero, t_load, t_force, t_tick, pend_clear;

    function automatic logic [CNT_W-1:0] dur_load(input state_t s);
        case (s)
            NS_GREEN, EW_GREEN:   return G_LOAD;
            NS_YELLOW, EW_YELLOW: return Y_LOAD;
            default:              return C_LOAD;
        endcase
    endfunction

    phase_timer #(
        .CNT_W       (CNT_W),
        .FORCE_VALUE (MIN_LOAD)
    ) u_timer (
        .clk        (clk),
        .rst        (rst),
        .rst_value  (rst_type ? G_LOAD : C_LOAD),
        .load       (t_load),
        .load_value (t_load_value),
        .force_load (t_force),
        .tick       (t_tick),
        .cnt        (cnt),
        .zero       (zero)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= rst_type ? NS_GREEN : CLEAR_B;
            ped_pend <= 1'b0;
        end else begin
            state    <= state_next;
            ped_pend <= pend_clear ? 1'b0 : (ped_pend | ped_req);
        end
    end

`ifdef TRAFFIC_FLASH_MODE_EN
    logic flash_on;

    // Every FLASH entry starts on the lit half so the first flash cycle shows yellow.
    always_ff @(posedge clk) begin
        if (rst || state != FLASH) begin
            flash_on <= 1'b1;
        end else if (tick) begin
            flash_on <= ~flash_on;
        end
    end

    assign t_tick = tick && (state != FLASH);
`else
    assign t_tick = tick;
`endif

    always_comb begin
        state_next   = state;
        t_load       = 1'b0;
        t_load_value = C_LOAD;
        t_force      = 1'b0;
`ifdef TRAFFIC_FLASH_MODE_EN
        if (flash_req) begin
            state_next = FLASH;
        end else if (state == FLASH) begin
            state_next   = CLEAR_B;
            t_load       = 1'b1;
            t_load_value = C_LOAD;
        end else
`endif
        if ((state == NS_GREEN || state == EW_GREEN) && ped_pend && cnt > MIN_LOAD) begin
            t_force = 1'b1;
        end else if (tick && zero) begin
            state_next   = next_phase(state);
            t_load       = 1'b1;
            t_load_value = dur_load(next_phase(state));
        end
        pend_clear = (state_next != state) && (state_next == CLEAR_A || state_next == CLEAR_B);
    end

    always_comb begin
        light_ns = LIGHT_RED;
        light_ew = LIGHT_RED;
        walk_ns  = 1'b0;
        walk_ew  = 1'b0;
        case (state)
            NS_GREEN:  begin light_ns = LIGHT_GREEN;  walk_ns = 1'b1; end
            NS_YELLOW: begin light_ns = LIGHT_YELLOW; walk_ns = 1'b1; end
            EW_GREEN:  begin light_ew = LIGHT_GREEN;  walk_ew = 1'b1; end
            EW_YELLOW: begin light_ew = LIGHT_YELLOW; walk_ew = 1'b1; end
`ifdef TRAFFIC_FLASH_MODE_EN
            FLASH: begin
                light_ns = flash_on ? LIGHT_YELLOW : LIGHT_DARK;
                light_ew = flash_on ? LIGHT_YELLOW : LIGHT_DARK;
            end
`endif
            default: ;
        endcase
    end

endmodule

// File: tb/tb_traffic_controller.sv
// Directed self-checking bench for traffic_controller at default parameters.
// Flash-mode steps are built only when TRAFFIC_FLASH_MODE_EN is defined.
module tb_traffic_controller;

    logic       clk = 1'b0;
    logic       rst, rst_type, tick, ped_req;
    logic [2:0] light_ns, light_ew;
    logic       walk_ns, walk_ew, ped_pend;
`ifdef TRAFFIC_FLASH_MODE_EN
    logic       flash_req = 1'b0;
`endif

    int unsigned passed = 0;
    int unsigned total  = 0;

    traffic_controller dut (
        .clk      (clk),
        .rst      (rst),
        .rst_type (rst_type),
        .tick     (tick),
        .ped_req  (ped_req),
`ifdef TRAFFIC_FLASH_MODE_EN
        .flash_req(flash_req),
`endif
        .light_ns (light_ns),
        .light_ew (light_ew),
        .walk_ns  (walk_ns),
        .walk_ew  (walk_ew),
        .ped_pend (ped_pend)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // Heads packed as {ns, ew}; walks packed as {walk_ns, walk_ew}.
    task automatic check_out(input string tag, input logic [5:0] heads, input logic [1:0] walks);
        check({tag, " heads"}, {2'b00, light_ns, light_ew}, {2'b00, heads});
        check({tag, " walks"}, {6'd0, walk_ns, walk_ew}, {6'd0, walks});
    endtask

    function automatic logic [5:0] cycle_heads(input int unsigned i);
        int unsigned p = i % 16;
        if (p < 5)  return {3'd1, 3'd4};
        if (p < 7)  return {3'd2, 3'd4};
        if (p < 8)  return {3'd4, 3'd4};
        if (p < 13) return {3'd4, 3'd1};
        if (p < 15) return {3'd4, 3'd2};
        return {3'd4, 3'd4};
    endfunction

    function automatic logic [1:0] cycle_walks(input int unsigned i);
        int unsigned p = i % 16;
        if (p < 7)            return 2'b10;
        if (p >= 8 && p < 15) return 2'b01;
        return 2'b00;
    endfunction

    initial begin
        rst = 1'b1; rst_type = 1'b1; tick = 1'b0; ped_req = 1'b0;
        step();
        check_out("reset ns-green", {3'd1, 3'd4}, 2'b10);
        check("reset pend", {7'd0, ped_pend}, 8'd0);
        check("reset cnt", 8'(dut.cnt), 8'd4);

        // Full cycle with a tick every clock.
        rst = 1'b0; tick = 1'b1;
        for (int unsigned i = 1; i <= 16; i++) begin
            step();
            check_out($sformatf("cycle %0d", i), cycle_heads(i), cycle_walks(i));
        end
        check("cycle wrap cnt", 8'(dut.cnt), 8'd4);

        // Truncation: request at cnt=4 of NS_GREEN.
        ped_req = 1'b1;
        step();
        ped_req = 1'b0;
        check("trunc pend set", {7'd0, ped_pend}, 8'd1);
        check("trunc cnt pre", 8'(dut.cnt), 8'd3);
        step();
        check("trunc cnt", 8'(dut.cnt), 8'd1);
        check_out("trunc still green", {3'd1, 3'd4}, 2'b10);
        step();
        check_out("trunc last green", {3'd1, 3'd4}, 2'b10);
        step();
        check_out("trunc ns yellow", {3'd2, 3'd4}, 2'b10);
        check("trunc yellow cnt", 8'(dut.cnt), 8'd1);
        step();
        check("trunc pend in yellow", {7'd0, ped_pend}, 8'd1);
        step();
        check_out("trunc clear_a", {3'd4, 3'd4}, 2'b00);
        check("trunc pend cleared", {7'd0, ped_pend}, 8'd0);
        step();
        check_out("ew green", {3'd4, 3'd1}, 2'b01);

        // Truncation coinciding with a tick, then mid-phase reset.
        ped_req = 1'b1;
        step();
        ped_req = 1'b0;
        check("prio cnt pre", 8'(dut.cnt), 8'd3);
        step();
        check("prio trunc over tick", 8'(dut.cnt), 8'd1);
        tick = 1'b0;
        step();
        check("no-tick hold", 8'(dut.cnt), 8'd1);
        tick = 1'b1;
        step();
        step();
        check_out("ew yellow", {3'd4, 3'd2}, 2'b01);
        check("pend held in ew yellow", {7'd0, ped_pend}, 8'd1);
        rst = 1'b1; rst_type = 1'b0; ped_req = 1'b1;
        step();
        check_out("reset clear_b", {3'd4, 3'd4}, 2'b00);
        check("reset0 cnt", 8'(dut.cnt), 8'd0);
        check("reset0 pend", {7'd0, ped_pend}, 8'd0);

        // Reset to clearance, then NS green after one tick.
        rst = 1'b0; ped_req = 1'b0;
        step();
        check_out("clear to ns green", {3'd1, 3'd4}, 2'b10);
        check("ns green cnt", 8'(dut.cnt), 8'd4);

        // Request at cnt=1: no truncation, normal exit.
        step(); step(); step();
        check("no-trunc cnt", 8'(dut.cnt), 8'd1);
        ped_req = 1'b1;
        step();
        ped_req = 1'b0;
        check("no-trunc pend", {7'd0, ped_pend}, 8'd1);
        check("no-trunc cnt0", 8'(dut.cnt), 8'd0);
        check_out("no-trunc green", {3'd1, 3'd4}, 2'b10);
        step();
        check_out("no-trunc yellow", {3'd2, 3'd4}, 2'b10);
        step();
        step();
        check_out("no-trunc clear_a", {3'd4, 3'd4}, 2'b00);
        check("no-trunc pend cleared", {7'd0, ped_pend}, 8'd0);

`ifdef TRAFFIC_FLASH_MODE_EN
        flash_req = 1'b1;
        step();
        check_out("flash 1", {3'd2, 3'd2}, 2'b00);
        step();
        check_out("flash 2", {3'd0, 3'd0}, 2'b00);
        step();
        check_out("flash 3", {3'd2, 3'd2}, 2'b00);
        step();
        check_out("flash 4", {3'd0, 3'd0}, 2'b00);
        flash_req = 1'b0;
        step();
        check_out("flash exit clear_b", {3'd4, 3'd4}, 2'b00);
        check("flash exit cnt", 8'(dut.cnt), 8'd0);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
